// File: rtl/reply_pattern_pkg.sv
// Shared types for the pattern replier: FSM states, pattern modes, LFSR step.
package reply_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_HDR_MODE, ST_HDR_LEN, ST_WAIT_TX, ST_SEND, ST_BUSY, ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_INC, MODE_DEC, MODE_LFSR, MODE_FILL
  } mode_e;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/reply_pattern_if.sv
// Dispatcher / UART RX / UART TX signals seen by the pattern replier.
interface reply_pattern_if;
  logic       activate;
  logic       done;
  logic       aborted;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_active;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    output activate, rx_ready, rx_data, tx_active, tx_done,
    input  done, aborted, tx_data, tx_start
  );

  modport slave (
    input  activate, rx_ready, rx_data, tx_active, tx_done,
    output done, aborted, tx_data, tx_start
  );
endinterface

// File: rtl/reply_pattern_gen.sv
// Pattern source: up/down counter, LFSR or fixed fill, selected when loaded.
module reply_pattern_gen
  import reply_pattern_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'h01,
  parameter logic [7:0] FILL_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  mode_e      mode_i,
  input  logic       step_i,
  output logic [7:0] byte_o
);

  mode_e      mode_q, mode_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    if (load_i) begin
      mode_d = mode_i;
      cnt_d  = (mode_i == MODE_DEC) ? 8'hFF : 8'h00;
      lfsr_d = LFSR_SEED;
    end else if (step_i) begin
      case (mode_q)
        MODE_INC:  cnt_d  = cnt_q + 8'd1;
        MODE_DEC:  cnt_d  = cnt_q - 8'd1;
        MODE_LFSR: lfsr_d = lfsr_next(lfsr_q);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_INC;
      cnt_q  <= 8'h00;
      lfsr_q <= LFSR_SEED;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    case (mode_q)
      MODE_LFSR: byte_o = lfsr_q;
      MODE_FILL: byte_o = FILL_BYTE;
      default:   byte_o = cnt_q;
    endcase
  end

endmodule

// File: rtl/reply_pattern.sv
// Test responder: reads mode + little-endian length from RX, streams len+1
// pattern bytes to TX, abortable by a magic RX byte.
module reply_pattern
  import reply_pattern_pkg::*;
#(
  parameter int         CNT_BYTES  = 2,
  parameter logic [7:0] ABORT_BYTE = 8'h55,
  parameter logic [7:0] LFSR_SEED  = 8'h01,
  parameter logic [7:0] FILL_BYTE  = 8'hA5
) (
  input logic           clk,
  input logic           rst_n,
  reply_pattern_if.slave bus
);

  localparam int LW = 8 * CNT_BYTES;
  localparam int IW = (CNT_BYTES > 1) ? $clog2(CNT_BYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(CNT_BYTES - 1);

  state_e        state_q, state_d;
  logic          rx_q;
  logic          rx_evt, in_stream, abort_hit, hdr_last;
  logic [IW-1:0] idx_q;
  logic [LW-1:0] len_q, len_nxt, rem_q;
  logic          abort_q, stop_q;
  logic          done_q, done_d, aborted_q, aborted_d, tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d, pat_byte;
  logic          pat_load, pat_step;

  assign rx_evt    = bus.rx_ready & ~rx_q;
  assign in_stream = (state_q == ST_WAIT_TX) || (state_q == ST_SEND) || (state_q == ST_BUSY);
  assign abort_hit = rx_evt && (bus.rx_data == ABORT_BYTE) && in_stream;
  assign hdr_last  = (idx_q == IDX_LAST);
  assign pat_load  = (state_q == ST_HDR_MODE) && rx_evt;
  assign pat_step  = (state_q == ST_SEND);

  always_comb begin
    len_nxt = len_q;
    len_nxt[idx_q*8 +: 8] = bus.rx_data;
  end

  reply_pattern_gen #(
    .LFSR_SEED (LFSR_SEED),
    .FILL_BYTE (FILL_BYTE)
  ) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pat_load),
    .mode_i (mode_e'(bus.rx_data[1:0])),
    .step_i (pat_step),
    .byte_o (pat_byte)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (bus.activate && !bus.rx_ready) state_d = ST_ARM;
      ST_ARM:      state_d = bus.activate ? ST_HDR_MODE : ST_IDLE;
      ST_HDR_MODE: if (!bus.activate) state_d = ST_IDLE;
                   else if (rx_evt)   state_d = ST_HDR_LEN;
      ST_HDR_LEN:  if (!bus.activate)          state_d = ST_IDLE;
                   else if (rx_evt && hdr_last) state_d = ST_WAIT_TX;
      ST_WAIT_TX:  if (!bus.activate)    state_d = ST_IDLE;
                   else if (abort_hit)   state_d = ST_DONE;
                   else if (!bus.tx_active) state_d = ST_SEND;
      ST_SEND:     state_d = ST_BUSY;
      // In-flight byte always completes; deactivation outranks abort/done
      ST_BUSY:     if (bus.tx_done) begin
                     if (stop_q || !bus.activate)         state_d = ST_IDLE;
                     else if (abort_q || abort_hit)       state_d = ST_DONE;
                     else if (rem_q == '0)                state_d = ST_DONE;
                     else                                 state_d = ST_WAIT_TX;
                   end
      ST_DONE:     if (!bus.activate && !bus.rx_ready && !bus.tx_active) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so decode from the state being entered
  always_comb begin
    done_d     = (state_d == ST_DONE);
    aborted_d  = (state_d == ST_DONE) && (abort_q || abort_hit);
    tx_start_d = (state_d == ST_SEND);
    tx_data_d  = (state_d == ST_SEND) ? pat_byte : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= 1'b0;
      idx_q      <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      abort_q    <= 1'b0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      rx_q       <= bus.rx_ready;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      case (state_q)
        ST_IDLE: begin
          idx_q   <= '0;
          len_q   <= '0;
          rem_q   <= '0;
          abort_q <= 1'b0;
          stop_q  <= 1'b0;
        end
        ST_HDR_MODE: if (rx_evt) idx_q <= '0;
        ST_HDR_LEN: if (rx_evt) begin
          len_q <= len_nxt;
          idx_q <= idx_q + 1'b1;
          if (hdr_last) rem_q <= len_nxt;
        end
        ST_BUSY: if (state_d == ST_WAIT_TX) rem_q <= rem_q - 1'b1;
        default: ;
      endcase
      if (abort_hit) abort_q <= 1'b1;
      if (!bus.activate && (state_q == ST_SEND || state_q == ST_BUSY)) stop_q <= 1'b1;
    end
  end

  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_reply_pattern.sv
// Scoreboard bench for reply_pattern: stimulus queues expected TX bytes,
// the TX model/monitor pops and compares on every tx_start.
module tb_reply_pattern;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reply_pattern_if bus();

  reply_pattern #(
    .CNT_BYTES  (2),
    .ABORT_BYTE (8'h55),
    .LFSR_SEED  (8'h01),
    .FILL_BYTE  (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         tx_cnt = 0;
  int         busy = 0;
  bit         in_flight = 0;

  // TX core model plus monitor: busy for 6 cycles per byte, then tx_done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      busy          = 0;
      in_flight     = 0;
      bus.tx_active = 1'b0;
      bus.tx_done   = 1'b0;
    end else begin
      bus.tx_done = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          bus.tx_done   = 1'b1;
          bus.tx_active = 1'b0;
          in_flight     = 0;
        end
      end
      if (bus.tx_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got start with data %02h, required no start", bus.tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.tx_data !== exp_b) begin
            errors++;
            $display("FAIL tx_byte[%0d]: got %02h, required %02h", tx_cnt, bus.tx_data, exp_b);
          end
        end
        checks++;
        if (bus.tx_active || in_flight) begin
          errors++;
          $display("FAIL tx_overlap[%0d]: got start while busy, required idle", tx_cnt);
        end
        tx_cnt++;
        bus.tx_active = 1'b1;
        in_flight     = 1;
        busy          = 6;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_hdr(input logic [7:0] mode, input logic [15:0] len);
    @(negedge clk);
    bus.activate = 1'b1;
    tick(3);
    send_byte(mode);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic wait_cnt(input string name, input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1;
      if (tx_cnt == target && bus.tx_active) ok = 1;
    end
    if (!ok) check({name, "_timeout"}, tx_cnt, target);
  endtask

  task automatic finish_run(input string name, input logic exp_abort);
    bit ok;
    ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.done) ok = 1;
    end
    check({name, "_done"}, bus.done, 1'b1);
    check({name, "_aborted"}, bus.aborted, exp_abort);
    check({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    bus.activate = 1'b0;
    tick(3);
    check({name, "_done_clr"}, bus.done, 1'b0);
  endtask

  int base;

  initial begin
    bus.activate = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    tick(2);
    check("rst_done", bus.done, 1'b0);
    check("rst_aborted", bus.aborted, 1'b0);
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // incrementing, len 3
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    start_hdr(8'h00, 16'h0003);
    finish_run("inc3", 1'b0);

    // decrementing, len 0 -> one byte
    exp_q = '{8'hFF};
    start_hdr(8'h01, 16'h0000);
    finish_run("dec0", 1'b0);

    // constant fill, upper mode bits ignored
    exp_q = '{8'hA5, 8'hA5};
    start_hdr(8'hF7, 16'h0001);
    finish_run("fill1", 1'b0);

    // LFSR
    exp_q = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    start_hdr(8'h02, 16'h0003);
    finish_run("lfsr3", 1'b0);

    // 257 bytes with FF->00 wrap
    base = tx_cnt;
    for (int i = 0; i < 257; i++) exp_q.push_back(8'(i));
    start_hdr(8'h00, 16'h0100);
    finish_run("inc256", 1'b0);
    check("inc256_count", tx_cnt - base, 257);

    // abort during 5th byte; a non-abort byte during the 2nd is ignored
    base = tx_cnt;
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    start_hdr(8'h00, 16'd100);
    wait_cnt("abort_b2", base + 2);
    send_byte(8'h33);
    wait_cnt("abort_b5", base + 5);
    send_byte(8'h55);
    finish_run("abort", 1'b1);
    check("abort_count", tx_cnt - base, 5);

    // drop activate mid-reply
    base = tx_cnt;
    for (int i = 0; i < 101; i++) exp_q.push_back(8'(i));
    start_hdr(8'h00, 16'd100);
    wait_cnt("drop", base + 3);
    bus.activate = 1'b0;
    exp_q.delete();
    tick(20);
    check("drop_done", bus.done, 1'b0);
    check("drop_aborted", bus.aborted, 1'b0);
    check("drop_tx_start", bus.tx_start, 1'b0);
    check("drop_count", tx_cnt - base, 3);

    // reset in the middle of the header
    @(negedge clk);
    bus.activate = 1'b1;
    tick(3);
    send_byte(8'h00);
    send_byte(8'h03);
    @(negedge clk);
    rst_n = 1'b0;
    bus.activate = 1'b0;
    tick(1);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_tx_start", bus.tx_start, 1'b0);
    check("midrst_tx_data", bus.tx_data, 8'h00);
    rst_n = 1'b1;
    tick(3);

    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    start_hdr(8'h00, 16'h0003);
    finish_run("after_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
